ddr_req_arbiter: RTL

Multi-port request front end for the DDR4 simulation model. It buffers read/write transactions from up to NUM_PORTS independent stimulus sources in per-port FIFOs. It arbitrates between ports and presents one transaction at a time to the controller as a one-cycle `act_cmd` pulse with address, data and direction. It honours `dev_busy` and a programmable minimum spacing between commands, generalising the single-source, fixed-spacing stimulus path to N sources with selectable arbitration.

---
 rtl/ddr_req_arbiter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter
// ---------------------------------------------------------------------------
// Multi-port request front end for the DDR4 simulation model. Each requestor
// port owns a small FIFO of {addr, data, rw} entries. An issue FSM picks one
// non-empty port at a time, either round-robin or fixed priority with port 0
// highest. It presents the popped entry to the controller as a one-cycle
// o_act_cmd strobe. Strobes are never closer together than MIN_GAP cycles,
// and no grant is made while the controller reports busy.
//
// Ports:
//   i_clock       single clock, all logic on the rising edge
//   i_reset       synchronous active-high reset
//   i_req_valid   per-port request valid
//   o_req_ready   per-port FIFO can accept (decoded from the registered count)
//   i_req_addr    per-port address, port p at [p*ADDR_W +: ADDR_W]
//   i_req_data    per-port write data, same packing
//   i_req_rw      per-port direction, 1 = WRITE, 0 = READ
//   i_dev_busy    controller busy; holds grants while the FSM is idle
//   o_act_cmd     one-cycle command strobe
//   o_cmd_addr    address of the issued command (held until the next grant)
//   o_cmd_data    write data of the issued command
//   o_cmd_rw      direction of the issued command
//   o_cmd_port    source port of the issued command
//   o_fifo_empty  per-port FIFO empty flag (decoded from the registered count)
// ---------------------------------------------------------------------------
module ddr_req_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MIN_GAP   = 8,
  parameter int PRIO_MODE = 0,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NUM_PORTS-1:0]        i_req_valid,
  output logic [NUM_PORTS-1:0]        o_req_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] i_req_data,
  input  logic [NUM_PORTS-1:0]        i_req_rw,
  input  logic                        i_dev_busy,
  output logic                        o_act_cmd,
  output logic [ADDR_W-1:0]           o_cmd_addr,
  output logic [DATA_W-1:0]           o_cmd_data,
  output logic                        o_cmd_rw,
  output logic [PW-1:0]               o_cmd_port,
  output logic [NUM_PORTS-1:0]        o_fifo_empty
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int GW   = $clog2(MIN_GAP);

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(MIN_GAP - 1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);
  localparam logic [PW:0]   PORT_MOD  = (PW + 1)'(NUM_PORTS);

  typedef enum logic {
    ST_IDLE,
    ST_GAP
  } state_t;

  // FIFO storage and bookkeeping, one set per port
  logic [ADDR_W-1:0] r_memAddr [NUM_PORTS][DEPTH];
  logic [DATA_W-1:0] r_memData [NUM_PORTS][DEPTH];
  logic              r_memRw   [NUM_PORTS][DEPTH];
  logic [PTRW-1:0]   r_wrPtr   [NUM_PORTS];
  logic [PTRW-1:0]   r_rdPtr   [NUM_PORTS];
  logic [CW-1:0]     r_count   [NUM_PORTS];

  // Issue FSM and arbitration state
  state_t            r_state;
  state_t            w_nextState;
  logic [GW-1:0]     r_gapCnt;
  logic [GW-1:0]     w_nextGap;
  logic [PW-1:0]     r_rrPtr;

  logic [NUM_PORTS-1:0] w_push;
  logic [NUM_PORTS-1:0] w_pop;
  logic                 w_anyReq;
  logic                 w_grant;
  logic                 w_found;
  logic [PW-1:0]        w_winner;
  logic [PW-1:0]        w_cand;
  logic [PW:0]          w_sum;
  logic [ADDR_W-1:0]    w_popAddr;
  logic [DATA_W-1:0]    w_popData;
  logic                 w_popRw;

  // Ready and empty come straight from the registered counts. Ready does not
  // look at a same-cycle pop, so a full FIFO only reopens the cycle after it
  // drains one entry.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : gStatus
    assign o_req_ready[g]  = (r_count[g] < FULL_CNT);
    assign o_fifo_empty[g] = (r_count[g] == '0);
    assign w_push[g]       = i_req_valid[g] & o_req_ready[g];
    assign w_pop[g]        = w_grant & (w_winner == PW'(g));
  end

  assign w_anyReq = ~(&o_fifo_empty);

  // Winner selection. Round-robin starts searching one past the last granted
  // port and wraps. Fixed priority takes the lowest non-empty index.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_cand   = '0;
    if (PRIO_MODE == 1) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!w_found && !o_fifo_empty[i]) begin
          w_found  = 1'b1;
          w_winner = PW'(i);
        end
      end
    end else begin
      for (int i = 1; i <= NUM_PORTS; i++) begin
        w_sum = {1'b0, r_rrPtr} + (PW + 1)'(i);
        if (w_sum >= PORT_MOD) begin
          w_sum = w_sum - PORT_MOD;
        end
        w_cand = w_sum[PW-1:0];
        if (!w_found && !o_fifo_empty[w_cand]) begin
          w_found  = 1'b1;
          w_winner = w_cand;
        end
      end
    end
  end

  // Head entry of the winning FIFO, registered onto the command outputs on grant
  always_comb begin
    w_popAddr = r_memAddr[w_winner][r_rdPtr[w_winner]];
    w_popData = r_memData[w_winner][r_rdPtr[w_winner]];
    w_popRw   = r_memRw[w_winner][r_rdPtr[w_winner]];
  end

  // Entry storage has no reset; clearing the pointers and counts is enough to
  // discard whatever was queued.
  always_ff @(posedge i_clock) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_push[p]) begin
        r_memAddr[p][r_wrPtr[p]] <= i_req_addr[p*ADDR_W +: ADDR_W];
        r_memData[p][r_wrPtr[p]] <= i_req_data[p*DATA_W +: DATA_W];
        r_memRw[p][r_wrPtr[p]]   <= i_req_rw[p];
      end
    end
  end

  // Pointer and count bookkeeping. A simultaneous push and pop leaves the
  // count unchanged; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_wrPtr[p] <= '0;
        r_rdPtr[p] <= '0;
        r_count[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_push[p]) begin
          r_wrPtr[p] <= r_wrPtr[p] + 1'b1;
        end
        if (w_pop[p]) begin
          r_rdPtr[p] <= r_rdPtr[p] + 1'b1;
        end
        case ({w_push[p], w_pop[p]})
          2'b10:   r_count[p] <= r_count[p] + 1'b1;
          2'b01:   r_count[p] <= r_count[p] - 1'b1;
          default: r_count[p] <= r_count[p];
        endcase
      end
    end
  end

  // Issue FSM state register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_gapCnt <= '0;
    end else begin
      r_state  <= w_nextState;
      r_gapCnt <= w_nextGap;
    end
  end

  // Issue FSM next state. dev_busy only matters while idle; once a command
  // has gone out the gap runs to completion regardless of busy.
  always_comb begin
    w_nextState = r_state;
    w_nextGap   = r_gapCnt;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_dev_busy && w_anyReq) begin
          w_grant     = 1'b1;
          w_nextState = ST_GAP;
          w_nextGap   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        w_nextGap = r_gapCnt - 1'b1;
        if (r_gapCnt == GAP_ONE) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextGap   = '0;
      end
    endcase
  end

  // Command outputs. The strobe is high only for the cycle after a grant;
  // the payload fields hold their last value between grants.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_act_cmd  <= 1'b0;
      o_cmd_addr <= '0;
      o_cmd_data <= '0;
      o_cmd_rw   <= 1'b0;
      o_cmd_port <= '0;
      r_rrPtr    <= LAST_PORT;
    end else begin
      o_act_cmd <= w_grant;
      if (w_grant) begin
        o_cmd_addr <= w_popAddr;
        o_cmd_data <= w_popData;
        o_cmd_rw   <= w_popRw;
        o_cmd_port <= w_winner;
        r_rrPtr    <= w_winner;
      end
    end
  end

endmodule
